// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with loader port arbitration
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        done,
  output logic        fault
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        pc_in_range;
  logic        slot_free;
  logic        redirect_ok;

  assign pc_in_range = (pc <= LAST_PC);
  assign slot_free   = !out_valid || out_ready;
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);

  // The loader owns the memory port only while idle; fetch owns it otherwise.
  always_comb begin
    imem_addr  = pc;
    imem_we    = 1'b0;
    imem_wdata = 32'd0;
    if (state == S_IDLE) begin
      imem_addr  = load_addr;
      imem_we    = load_we;
      imem_wdata = load_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
          end
        end
        S_FETCH: begin
          // A redirect flushes the pending word even if decode is taking it now.
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (redirect_ok) begin
              pc <= redirect_pc;
            end else begin
              fault <= 1'b1;
              state <= S_ERR;
            end
          end else if (slot_free) begin
            if (pc_in_range) begin
              out_instr <= imem_rdata;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + 32'd4;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        default: begin
          if (start) begin
            done  <= 1'b0;
            fault <= 1'b0;
            pc    <= RESET_PC;
            state <= S_FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl against a stream-level model
module tb_imem_fetch_ctrl;

  localparam int MEMB = 24;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

  logic        clk, reset, start, load_we, redirect_valid, out_ready;
  logic [31:0] load_addr, load_wdata, redirect_pc;
  logic [31:0] imem_addr, imem_wdata, imem_rdata, out_instr, out_pc;
  logic        imem_we, out_valid, done, fault;

  imem_fetch_ctrl #(.RESET_PC(32'd0), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .reset(reset), .start(start), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .done(done), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed little-endian memory seen by the DUT.
  logic [7:0] mem [0:63];
  always_ff @(posedge clk) begin
    if (imem_we && imem_addr <= 32'd60) begin
      mem[imem_addr[5:0]]         <= imem_wdata[7:0];
      mem[imem_addr[5:0] + 6'd1]  <= imem_wdata[15:8];
      mem[imem_addr[5:0] + 6'd2]  <= imem_wdata[23:16];
      mem[imem_addr[5:0] + 6'd3]  <= imem_wdata[31:24];
    end
  end
  assign imem_rdata = (imem_addr <= 32'd60) ?
    {mem[imem_addr[5:0] + 6'd3], mem[imem_addr[5:0] + 6'd2],
     mem[imem_addr[5:0] + 6'd1], mem[imem_addr[5:0]]} : 32'd0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream-level reference: program image, fetch cursor, holding slot.
  logic [31:0] gmem [6];
  int          m_mode;
  bit          m_known = 0;
  logic [31:0] m_pc, m_instr, m_opc;
  bit          m_valid, m_done, m_fault;
  logic [31:0] acc_pc [$];
  logic [31:0] acc_in [$];

  always @(negedge clk) begin
    if (m_known) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("out_pc", out_pc, m_opc);
      check("out_instr", out_instr, m_instr);
      check("done", {31'd0, done}, {31'd0, m_done});
      check("fault", {31'd0, fault}, {31'd0, m_fault});
      check("imem_we", {31'd0, imem_we}, (m_mode == M_IDLE) ? {31'd0, load_we} : 32'd0);
      check("imem_addr", imem_addr, (m_mode == M_IDLE) ? load_addr : m_pc);
      check("imem_wdata", imem_wdata, (m_mode == M_IDLE) ? load_wdata : 32'd0);
      if (!reset && m_mode == M_RUN && m_valid && out_ready && !redirect_valid) begin
        acc_pc.push_back(m_opc);
        acc_in.push_back(m_instr);
      end
    end
    if (reset) begin
      m_known = 1; m_mode = M_IDLE; m_pc = 0; m_valid = 0;
      m_instr = 0; m_opc = 0; m_done = 0; m_fault = 0;
    end else if (m_known) begin
      if (m_mode == M_IDLE) begin
        if (load_we && load_addr <= 32'(MEMB - 4)) gmem[load_addr / 4] = load_wdata;
        if (start) begin m_mode = M_RUN; m_pc = 0; end
      end else if (m_mode == M_RUN) begin
        if (redirect_valid) begin
          m_valid = 0;
          if (redirect_pc % 4 == 0 && redirect_pc <= 32'(MEMB - 4)) m_pc = redirect_pc;
          else begin m_fault = 1; m_mode = M_ERR; end
        end else if (!m_valid || out_ready) begin
          if (m_pc <= 32'(MEMB - 4)) begin
            m_instr = gmem[m_pc / 4]; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
          end else begin
            m_valid = 0; m_done = 1; m_mode = M_DONE;
          end
        end
      end else if (start) begin
        m_done = 0; m_fault = 0; m_pc = 0; m_mode = M_RUN;
      end
    end
  end

  logic [31:0] prog [6];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 6; i++) begin
      load_we = 1; load_addr = 32'(i * 4); load_wdata = prog[i];
      cyc();
    end
    load_we = 0; load_addr = 0; load_wdata = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic run_to_done();
    int n = 0;
    while (!done && n < 40) begin cyc(); n++; end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_seq_stream(input string name);
    check({name, "_count"}, 32'(acc_pc.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_pc.size(); i++) begin
      check({name, "_pc"}, acc_pc[i], 32'(i * 4));
      check({name, "_instr"}, acc_in[i], prog[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests", tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] e3 [8];
    int n;
    prog[0] = 32'h00940333; prog[1] = 32'h413903b3; prog[2] = 32'h00f768b3;
    prog[3] = 32'h00d67fb3; prog[4] = 32'h017b4e33; prog[5] = 32'h01bdaf33;
    e3 = '{32'd0, 32'd4, 32'd8, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
    reset = 1; start = 0; load_we = 0; load_addr = 0; load_wdata = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 1;
    cyc(); cyc();
    reset = 0;
    check("reset_flags", {28'd0, out_valid, done, fault, imem_we}, 32'd0);
    check("reset_out_pc", out_pc, 32'd0);

    // Straight-line run: valid at N+2, done at N+8.
    load_prog();
    acc_pc.delete(); acc_in.delete();
    pulse_start();
    check("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    check("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_n2_pc", out_pc, 32'd0);
    check("lat_n2_instr", out_instr, 32'h00940333);
    repeat (5) cyc();
    check("n7_done", {31'd0, done}, 32'd0);
    cyc();
    check("n8_done", {31'd0, done}, 32'd1);
    check_seq_stream("run1");

    // Back-pressure while out_pc=8.
    acc_pc.delete(); acc_in.delete();
    pulse_start();
    cyc(); cyc(); cyc();
    check("stall_entry_pc", out_pc, 32'd8);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall_instr", out_instr, 32'h00f768b3);
      check("stall_fetch_pc", imem_addr, 32'd12);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      cyc();
    end
    out_ready = 1;
    run_to_done();
    check_seq_stream("stall");

    // Redirect to 4 while out_pc=12 is offered.
    acc_pc.delete(); acc_in.delete();
    pulse_start();
    n = 0;
    while (!(out_valid && out_pc == 32'd12) && n < 40) begin cyc(); n++; end
    check("redir_found12", out_pc, 32'd12);
    redirect_valid = 1; redirect_pc = 32'd4;
    cyc();
    redirect_valid = 0;
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    cyc();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'd4);
    check("redir_instr", out_instr, 32'h413903b3);
    run_to_done();
    check("redir_count", 32'(acc_pc.size()), 32'd8);
    for (int i = 0; i < 8 && i < acc_pc.size(); i++) check("redir_stream", acc_pc[i], e3[i]);

    // Loader writes ignored during fetch, then bad redirects.
    pulse_start();
    load_we = 1; load_addr = 0; load_wdata = 32'hFFFFFFFF;
    cyc();
    check("ignored_we", {31'd0, imem_we}, 32'd0);
    cyc();
    redirect_valid = 1; redirect_pc = 32'd6;
    cyc();
    redirect_valid = 0; load_we = 0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    check("mis_hold", {31'd0, fault}, 32'd1);
    pulse_start();
    check("mis_clear", {31'd0, fault}, 32'd0);
    cyc();
    check("refetch_pc", out_pc, 32'd0);
    check("refetch_instr", out_instr, 32'h00940333);
    redirect_valid = 1; redirect_pc = 32'd24;
    cyc();
    redirect_valid = 0;
    check("oor_fault", {31'd0, fault}, 32'd1);
    check("oor_valid", {31'd0, out_valid}, 32'd0);
    pulse_start();
    cyc();
    check("oor_refetch", out_instr, 32'h00940333);

    // Reset while stalled.
    out_ready = 0;
    cyc(); cyc();
    load_addr = 32'h10;
    reset = 1;
    cyc();
    reset = 0;
    check("rst_flags", {29'd0, out_valid, done, fault}, 32'd0);
    check("rst_idle_addr", imem_addr, 32'h10);
    out_ready = 1;
    load_prog();
    acc_pc.delete(); acc_in.delete();
    pulse_start();
    run_to_done();
    check_seq_stream("post_reset");

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = (($urandom % 5) == 0) ? 32'($urandom % 32) : 32'(($urandom % 6) * 4);
      start          = ($urandom % 30) == 0;
      reset          = ($urandom % 250) == 0;
      load_we        = $urandom % 2;
      load_addr      = 32'(($urandom % 6) * 4);
      load_wdata     = $urandom;
      cyc();
    end
    reset = 0; start = 0; load_we = 0; redirect_valid = 0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the byte-addressed, little-endian instruction memory (combinational 32-bit read at a byte address) for the single-cycle core.
- Owns the PC: steps it by 4, honours branch/jump redirects and back-pressure from decode, and presents {PC, instruction} on a valid/ready interface.
- Also arbitrates the memory's single address port between a program-loader write path (used only while not fetching) and instruction fetch.
- Signals program end and misaligned-redirect faults.

Parameters:
- RESET_PC, 0, fetch start address after start pulse (must be multiple of 4)
- MEM_BYTES, 24, memory size in bytes (multiple of 4); valid fetch addresses 0..MEM_BYTES-4

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  pulse: begin fetch at RESET_PC (accepted in IDLE, DONE, ERR)
- load_we  in  1  loader word write request (accepted only in IDLE)
- load_addr  in  32  loader byte address (word-aligned)
- load_wdata  in  32  loader write word
- imem_addr  out  32  shared memory byte address
- imem_we  out  1  memory write strobe (writes bytes addr..addr+3, LSB at addr)
- imem_wdata  out  32  memory write data
- imem_rdata  in  32  combinational read word at imem_addr
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  32  target address
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_instr  out  32  instruction word
- out_pc  out  32  address of out_instr
- done  out  1  program end reached and drained
- fault  out  1  misaligned or out-of-range redirect seen

Behaviour:
- States: IDLE, FETCH, DONE, ERR. On reset: state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, done=0, fault=0, imem_we=0.
- Address mux (combinational): IDLE: imem_addr=load_addr, imem_we=load_we, imem_wdata=load_wdata. All other states: imem_addr=pc, imem_we=0, imem_wdata=0.
- load_we outside IDLE is ignored (no write, no error).
- IDLE: start -> FETCH, pc<=RESET_PC. If start and load_we in the same cycle, the write completes that cycle, then FETCH.
- FETCH capture: when (!out_valid || out_ready) and pc<=MEM_BYTES-4: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4. Latency: start at cycle N -> out_valid=1 from cycle N+2. Throughput 1 instr/cycle with out_ready=1.
- Stall: out_valid && !out_ready holds out_instr, out_pc, pc and out_valid stable.
- Redirect (FETCH only; highest priority): out_valid<=0 (pending instruction flushed even if out_ready=1 in that cycle; it counts as not accepted), no capture. If redirect_pc[1:0]==0 and redirect_pc<=MEM_BYTES-4: pc<=redirect_pc, first target instruction valid 1 cycle later. Otherwise: fault<=1, state->ERR, pc unchanged.
- End: pc>MEM_BYTES-4 (sequential wrap is not allowed) -> no capture. When out_valid==0 or the final handshake completes, state->DONE, done<=1. A redirect arriving before that point still applies.
- DONE/ERR: out_valid=0. done or fault held until start (clears both, pc<=RESET_PC, ->FETCH) or reset.
- Arithmetic: pc+4 is 32-bit unsigned; the range check uses the pre-increment pc.
- reset mid-operation overrides everything, including redirect and start, in the same cycle.

Test Plan:
- Load 6 words at addresses 0,4,...,20 (0x00940333, 0x413903b3, 0x00f768b3, 0x00d67fb3, 0x017b4e33, 0x01bdaf33), start at cycle N, out_ready=1 -> out_valid from N+2; 6 consecutive handshakes with out_pc 0..20 and matching words; done=1 at N+8; imem_we never asserted after N.
- Same program, out_ready low for 3 cycles while out_pc=8 -> out_instr stays 0x00f768b3 and pc stays 12 throughout; the stream resumes with no loss or duplicate.
- Redirect to 4 while out_pc=12 is valid -> out_valid=0 next cycle; the following valid has out_pc=4 and instr 0x413903b3; pc=12 instruction never accepted.
- Redirect to 6 (misaligned) and separately to 24 -> fault=1, state ERR, out_valid=0; a start pulse clears fault and refetches from 0.
- load_we=1 during FETCH with load_addr=0, load_wdata=0xFFFFFFFF -> no write; the refetch of address 0 after restart still returns 0x00940333.
- reset asserted for one cycle while stalled in FETCH -> next cycle out_valid=0, done=0, fault=0, state IDLE; load and start work normally.
